// File: rtl/random_byte_arbiter_pkg.sv
// Shared types and helpers for the random byte arbiter.
package random_byte_arbiter_pkg;

  // Arbiter controller states
  typedef enum logic [2:0] {
    ST_ARB      = 3'd0,
    ST_WAIT_SRC = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WAIT_LOW = 3'd3,
    ST_DELIVER  = 3'd4,
    ST_FAIL     = 3'd5
  } arb_state_e;

  // Width and ceiling of the repetition counter
  localparam int          REP_W   = 8;
  localparam logic [7:0]  REP_MAX = 8'hFF;

  // Next repetition count: restart at 1 on a new byte, saturate on repeats
  function automatic logic [REP_W-1:0] rep_next(input logic [REP_W-1:0] cnt,
                                                input logic             same);
    logic [REP_W-1:0] nxt;
    if (!same) begin
      nxt = 8'd1;
    end else if (cnt == REP_MAX) begin
      nxt = REP_MAX;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/random_byte_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N (which need not be a power of two).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0] cand;

  // Scan candidates ptr, ptr+1, ... (mod N) and take the first requester
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid                = 1'b1;
        idx                  = cand[IW-1:0];
        grant[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/random_byte_arbiter.sv
// Shares one valid/received random-byte source among NUM_REQ consumers with
// round-robin bursts, and runs a repetition-count health test on every byte.
module random_byte_arbiter
  import random_byte_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST     = 4,
  parameter int REP_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         src_data,
  input  logic               src_valid,
  output logic               src_received,
  input  logic [NUM_REQ-1:0] req,
  output logic [7:0]         out_data,
  output logic [NUM_REQ-1:0] out_valid,
  input  logic [NUM_REQ-1:0] out_ack,
  output logic [NUM_REQ-1:0] grant,
  output logic               health_fail
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [7:0]         last_q, last_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               health_fail_q, health_fail_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;

  logic               req_granted;
  logic               ack_granted;
  logic [IW-1:0]      ptr_after;
  logic [BW-1:0]      burst_inc;
  logic [REP_W-1:0]   rep_new;
  logic               rep_trip;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Helper terms: granted requester status, pointer wrap, counter increments
  always_comb begin
    req_granted = |(req & grant_q);
    ack_granted = |(out_ack & grant_q);
    if (idx_q == IW'(NUM_REQ - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = idx_q + IW'(1);
    end
    burst_inc = burst_q + BW'(1);
    rep_new   = rep_next(rep_q, src_data == last_q);
    rep_trip  = (rep_new >= 8'(REP_LIMIT));
  end

  // Next-state and datapath updates for the arbitration/handshake sequence
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    burst_d       = burst_q;
    rep_d         = rep_q;
    last_d        = last_q;
    out_data_d    = out_data_q;
    health_fail_d = health_fail_q;

    case (state_q)
      ST_ARB: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          burst_d = '0;
          state_d = ST_WAIT_SRC;
        end else begin
          grant_d = '0;
        end
      end

      ST_WAIT_SRC: begin
        if (!req_granted) begin
          grant_d = '0;
          state_d = ST_ARB;
        end else if (src_valid) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        out_data_d = src_data;
        rep_d      = rep_new;
        last_d     = src_data;
        if (rep_trip) begin
          health_fail_d = 1'b1;
          grant_d       = '0;
          state_d       = ST_FAIL;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end

      ST_WAIT_LOW: begin
        if (!src_valid) begin
          state_d = ST_DELIVER;
        end
      end

      ST_DELIVER: begin
        if (ack_granted) begin
          burst_d = burst_inc;
          if ((burst_inc == BW'(BURST)) || !req_granted) begin
            ptr_d   = ptr_after;
            grant_d = '0;
            state_d = ST_ARB;
          end else begin
            state_d = ST_WAIT_SRC;
          end
        end
      end

      ST_FAIL: begin
        grant_d = '0;
      end

      default: begin
        grant_d = '0;
        state_d = ST_ARB;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ARB;
      grant_q       <= '0;
      idx_q         <= '0;
      ptr_q         <= '0;
      burst_q       <= '0;
      rep_q         <= '0;
      last_q        <= '0;
      out_data_q    <= '0;
      health_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      idx_q         <= idx_d;
      ptr_q         <= ptr_d;
      burst_q       <= burst_d;
      rep_q         <= rep_d;
      last_q        <= last_d;
      out_data_q    <= out_data_d;
      health_fail_q <= health_fail_d;
    end
  end

  // Outputs decoded from registered state so reset clears them immediately
  always_comb begin
    grant        = grant_q;
    out_valid    = (state_q == ST_DELIVER) ? grant_q : '0;
    src_received = (state_q == ST_CAPTURE);
    out_data     = out_data_q;
    health_fail  = health_fail_q;
  end

endmodule

// File: tb/tb_random_byte_arbiter.sv
// Randomised and directed bench for random_byte_arbiter with a
// transaction-level reference model of grants, bytes and health test.
module tb_random_byte_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int BURST     = 4;
  localparam int REP_LIMIT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         src_data;
  logic               src_valid;
  logic               src_received;
  logic [NUM_REQ-1:0] req;
  logic [7:0]         out_data;
  logic [NUM_REQ-1:0] out_valid;
  logic [NUM_REQ-1:0] out_ack;
  logic [NUM_REQ-1:0] grant;
  logic               health_fail;

  random_byte_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .BURST     (BURST),
    .REP_LIMIT (REP_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_received (src_received),
    .req          (req),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .grant        (grant),
    .health_fail  (health_fail)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int                 exp_ptr, cur_idx, deliv_cnt, rcv_count, wait_cnt, last_wait, m_rep;
  bit                 pend, exp_hf, ack_evt, ack_req_hi, prev_rcv;
  logic [7:0]         pend_byte, m_last;
  logic [NUM_REQ-1:0] prev_grant;
  logic [7:0]         deliv_log[$];
  logic [NUM_REQ-1:0] grant_log[$];
  int                 burst_log[$];

  // stimulus controls
  int         src_mode, low_cnt, gap, ack_delay, drop_after;
  bit         rand_ack_delay, noise, rand_req;
  logic [7:0] src_q[$];
  logic [7:0] inc_byte;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int o = 0; o < NUM_REQ; o++) begin
      int i;
      i = (p + o) % NUM_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_ptr = 0; cur_idx = -1; deliv_cnt = 0; rcv_count = 0; wait_cnt = 0; last_wait = 0;
    m_rep = 0; m_last = 8'h00; pend = 0; pend_byte = 8'h00; exp_hf = 0; ack_evt = 0;
    ack_req_hi = 0; prev_rcv = 0; prev_grant = '0;
    deliv_log.delete(); grant_log.delete(); burst_log.delete(); src_q.delete();
    src_mode = 0; low_cnt = 10; gap = 0; ack_delay = 0; drop_after = 0;
    rand_ack_delay = 0; noise = 0; rand_req = 0; inc_byte = 8'h10;
    req = '0; out_ack = '0; src_valid = 1'b0; src_data = 8'h00;
  endtask

  task automatic checkCycle();
    int e;
    logic [NUM_REQ-1:0] exp_g;
    checkOutput("health_fail", health_fail, exp_hf);
    checkOutput("grant_onehot", $countones(grant) <= 1, 1);
    if (ack_evt) begin
      exp_g = (deliv_cnt < BURST && ack_req_hi) ? NUM_REQ'(1 << cur_idx) : '0;
      checkOutput("grant_after_ack", grant, exp_g);
      if (exp_g == '0) begin
        exp_ptr = (cur_idx + 1) % NUM_REQ;
        burst_log.push_back(deliv_cnt);
        cur_idx = -1;
      end
    end else if (prev_grant == '0 && !exp_hf) begin
      e = pick(req, exp_ptr);
      checkOutput("arb_grant", grant, (e < 0) ? 0 : (1 << e));
      if (grant != '0) begin
        cur_idx = (e < 0) ? 0 : e;
        deliv_cnt = 0;
        grant_log.push_back(grant);
      end
    end else if (prev_grant != '0 && grant != prev_grant) begin
      checkOutput("grant_release", grant, 0);
      checkOutput("release_cause", (cur_idx >= 0 && req[cur_idx] == 1'b0) || exp_hf, 1);
      checkOutput("release_pending", pend, 0);
      burst_log.push_back(deliv_cnt);
      cur_idx = -1;
    end
    if (src_received) begin
      checkOutput("rcv_width", prev_rcv, 0);
      checkOutput("rcv_src_valid", src_valid, 1);
      checkOutput("rcv_granted", grant != '0, 1);
      checkOutput("rcv_while_pending", pend, 0);
      if (src_data == m_last) m_rep = (m_rep < 255) ? m_rep + 1 : 255;
      else m_rep = 1;
      m_last = src_data;
      rcv_count++;
      if (m_rep >= REP_LIMIT) exp_hf = 1;
      else begin
        pend = 1;
        pend_byte = src_data;
      end
    end
    prev_rcv = src_received;
    if (out_valid != '0) begin
      checkOutput("out_valid", out_valid, (cur_idx >= 0) ? (1 << cur_idx) : 0);
      checkOutput("deliver_pending", pend, 1);
      checkOutput("out_data", out_data, pend_byte);
    end
    prev_grant = grant;
    ack_evt = 0;
  endtask

  task automatic applyStimulus();
    if (rand_req) begin
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
    end
    out_ack = noise ? NUM_REQ'($urandom) : '0;
    if (out_valid != '0 && cur_idx >= 0) begin
      out_ack[cur_idx] = 1'b0;
      if (wait_cnt >= ack_delay) begin
        out_ack[cur_idx] = 1'b1;
        deliv_cnt++;
        pend = 0;
        deliv_log.push_back(out_data);
        last_wait = wait_cnt;
        wait_cnt = 0;
        ack_evt = 1;
        if (drop_after > 0 && deliv_cnt == drop_after) req[cur_idx] = 1'b0;
        ack_req_hi = req[cur_idx];
        if (rand_ack_delay) ack_delay = $urandom_range(3);
      end else begin
        wait_cnt++;
      end
    end
    if (src_valid && src_received) begin
      src_valid = 1'b0;
      low_cnt = 0;
      gap = $urandom_range(2);
    end else if (!src_valid) begin
      low_cnt++;
      if (low_cnt >= 2 + gap) begin
        if (src_mode == 0 && src_q.size() > 0) begin
          src_data = src_q.pop_front(); src_valid = 1'b1;
        end else if (src_mode == 1) begin
          inc_byte = inc_byte + 8'd1; src_data = inc_byte; src_valid = 1'b1;
        end else if (src_mode == 2) begin
          src_data = 8'($urandom); src_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkCycle();
    applyStimulus();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_src_received", src_received, 0);
    checkOutput("rst_health_fail", health_fail, 0);
    rst = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_health_fail"}, health_fail, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] exp_rr [5];
    bit seen;
    rst = 1'b1;
    model_reset();

    // single requester, three distinct bytes
    do_reset();
    src_q = '{8'h11, 8'h22, 8'h33};
    req = 4'b0001;
    run(60);
    checkOutput("single_count", deliv_log.size(), 3);
    checkOutput("single_b0", (deliv_log.size() > 0) ? deliv_log[0] : 8'hxx, 8'h11);
    checkOutput("single_b1", (deliv_log.size() > 1) ? deliv_log[1] : 8'hxx, 8'h22);
    checkOutput("single_b2", (deliv_log.size() > 2) ? deliv_log[2] : 8'hxx, 8'h33);
    checkOutput("single_rcv", rcv_count, 3);

    // round robin with all requesters active
    do_reset();
    src_mode = 1;
    req = 4'b1111;
    for (int k = 0; k < 600 && grant_log.size() < 5; k++) step();
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("rr_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 4'bxxxx, exp_rr[i]);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rr_burst%0d", i), (i < burst_log.size()) ? burst_log[i] : -1, BURST);

    // early release of requester 2 moves the pointer to 3
    do_reset();
    src_mode = 1;
    drop_after = 2;
    req = 4'b0100;
    run(60);
    checkOutput("early_grant", (grant_log.size() > 0) ? grant_log[0] : 4'bxxxx, 4'b0100);
    checkOutput("early_bytes", (burst_log.size() > 0) ? burst_log[0] : -1, 2);
    checkOutput("early_idle", grant, 0);
    drop_after = 0;
    req = 4'b1001;
    run(30);
    checkOutput("ptr_after_release", (grant_log.size() > 1) ? grant_log[1] : 4'bxxxx, 4'b1000);

    // slow consumer holds the byte for ten cycles
    do_reset();
    src_q = '{8'h5A, 8'h6B};
    ack_delay = 10;
    req = 4'b0001;
    run(80);
    checkOutput("slow_count", deliv_log.size(), 2);
    checkOutput("slow_b0", (deliv_log.size() > 0) ? deliv_log[0] : 8'hxx, 8'h5A);
    checkOutput("slow_wait", last_wait, 10);
    checkOutput("slow_rcv", rcv_count, 2);

    // repetition health test on a stuck source
    do_reset();
    for (int i = 0; i < 20; i++) src_q.push_back(8'hA5);
    req = 4'b0001;
    run(150);
    checkOutput("health_delivered", deliv_log.size(), 7);
    checkOutput("health_rcv", rcv_count, 8);
    checkOutput("health_flag", health_fail, 1);
    checkOutput("health_grant", grant, 0);
    async_reset_check("hf_async");

    // asynchronous reset while a byte is being presented
    do_reset();
    src_mode = 2;
    ack_delay = 5;
    req = 4'b0001;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (out_valid != '0) seen = 1;
    end
    checkOutput("deliver_reached", seen, 1);
    async_reset_check("dlv_async");
    src_q = '{8'h77};
    req = 4'b0001;
    run(40);
    checkOutput("resume_count", deliv_log.size(), 1);
    checkOutput("resume_b0", (deliv_log.size() > 0) ? deliv_log[0] : 8'hxx, 8'h77);

    // long randomised run
    do_reset();
    src_mode = 2;
    rand_req = 1;
    noise = 1;
    rand_ack_delay = 1;
    run(3000);
    checkOutput("random_liveness", deliv_log.size() > 50, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
